// File: rtl/hold_queue.sv
// Synchronous valid/ready FIFO holding up to DEPTH words, with occupancy
// status and a flush that has priority over push and pop.
module hold_queue #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]    count_q, count_nxt;
  logic             full_q, empty_q, full_nxt, empty_nxt;
  logic             push_c, pop_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshakes depend only on registered status, never on the peer's strobe.
  assign push_c = in_valid && !full_q && !flush;
  assign pop_c  = out_ready && !empty_q && !flush;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count_q;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push_c) wr_ptr_nxt = ptr_inc(wr_ptr);
      if (pop_c)  rd_ptr_nxt = ptr_inc(rd_ptr);
      if (push_c && !pop_c)      count_nxt = count_q + CW'(1);
      else if (pop_c && !push_c) count_nxt = count_q - CW'(1);
    end
    full_nxt  = (count_nxt == CW'(DEPTH));
    empty_nxt = (count_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      count_q <= count_nxt;
      full_q  <= full_nxt;
      empty_q <= empty_nxt;
    end
  end

  // Storage is cleared only by reset; flush leaves stale words in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push_c) begin
      mem[wr_ptr] <= data_in;
    end
  end

  assign data_out  = mem[rd_ptr];
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign in_ready  = !full_q;
  assign out_valid = !empty_q;

endmodule

// File: tb/tb_hold_queue.sv
// Bench for hold_queue: directed scenarios on a DEPTH=4 instance and a
// randomized wrap-around run on a DEPTH=3 instance, both against queue models.
module tb_hold_queue;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [7:0] data_in, data_out;
  logic       in_valid, in_ready, out_valid, out_ready, flush, full, empty;
  logic [2:0] count;

  logic [7:0] data_in3, data_out3;
  logic       in_valid3, in_ready3, out_valid3, out_ready3, flush3, full3, empty3;
  logic [1:0] count3;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mq[$];
  logic [7:0] q3[$];

  always #5 clk = ~clk;

  hold_queue #(.WIDTH(8), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush), .count(count), .full(full),
    .empty(empty)
  );

  hold_queue #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in3), .in_valid(in_valid3),
    .in_ready(in_ready3), .data_out(data_out3), .out_valid(out_valid3),
    .out_ready(out_ready3), .flush(flush3), .count(count3), .full(full3),
    .empty(empty3)
  );

  // One clock of stimulus on the DEPTH=4 instance; updates the model from the
  // rules (flush clears, pop if non-empty, push if not full before the edge).
  task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    bit do_push, do_pop;
    in_valid  = iv;
    data_in   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      do_pop  = ordy && (mq.size() > 0);
      do_push = iv && (mq.size() < 4);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(d);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1 ||
        out_valid !== 1'b0 || data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_idle: count=%0d empty=%b full=%b in_ready=%b out_valid=%b data_out=%h, want 0 1 0 1 0 00",
               count, empty, full, in_ready, out_valid, data_out);
    end
    rst_n = 1'b1;
    mq.delete();
    q3.delete();
    cyc(1, 8'hC1, 0, 0);
    cyc(1, 8'hC2, 0, 0);
    cyc(1, 8'hC3, 0, 0);
    vectors++;
    if (count !== 3'd3 || data_out !== 8'hC1) begin
      miscompares++;
      $display("FAIL reset_prefill: count=%0d head=%h, want 3 c1", count, data_out);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (count !== 3'd0 || empty !== 1'b1 || in_ready !== 1'b1 ||
        out_valid !== 1'b0 || data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async: count=%0d empty=%b in_ready=%b out_valid=%b data_out=%h, want 0 1 1 0 00",
               count, empty, in_ready, out_valid, data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    q3.delete();
    cyc(1, 8'h5A, 0, 0);
    vectors++;
    if (count !== 3'd1 || out_valid !== 1'b1 || data_out !== 8'h5A) begin
      miscompares++;
      $display("FAIL reset_first_push: count=%0d out_valid=%b data_out=%h, want 1 1 5a",
               count, out_valid, data_out);
    end
    cyc(0, 8'h00, 1, 0);
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp_words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) cyc(1, exp_words[i], 0, 0);
    vectors++;
    if (count !== 3'd4 || full !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_full: count=%0d full=%b in_ready=%b, want 4 1 0", count, full, in_ready);
    end
    cyc(1, 8'h55, 0, 0);
    vectors++;
    if (count !== 3'd4 || data_out !== 8'h11) begin
      miscompares++;
      $display("FAIL fill_reject: count=%0d head=%h, want 4 11", count, data_out);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || data_out !== exp_words[i]) begin
        miscompares++;
        $display("FAIL drain_word%0d: out_valid=%b data_out=%h, want 1 %h",
                 i, out_valid, data_out, exp_words[i]);
      end
      cyc(0, 8'h00, 1, 0);
    end
    vectors++;
    if (empty !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL drain_empty: empty=%b out_valid=%b count=%0d, want 1 0 0", empty, out_valid, count);
    end
  endtask

  task automatic test_simultaneous();
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h02, 0, 0);
    cyc(1, 8'hAA, 1, 0);
    vectors++;
    if (count !== 3'd2 || data_out !== 8'h02) begin
      miscompares++;
      $display("FAIL simul_mid: count=%0d head=%h, want 2 02", count, data_out);
    end
    cyc(1, 8'h03, 0, 0);
    cyc(1, 8'h04, 0, 0);
    cyc(1, 8'hBB, 1, 0);
    vectors++;
    if (count !== 3'd3 || data_out !== 8'hAA || full !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_full: count=%0d head=%h full=%b, want 3 aa 0", count, data_out, full);
    end
    for (int n = 0; n < 8 && mq.size() > 0; n++) begin
      vectors++;
      if (out_valid !== 1'b1 || data_out !== mq[0]) begin
        miscompares++;
        $display("FAIL simul_drain: out_valid=%b data_out=%h, want 1 %h", out_valid, data_out, mq[0]);
      end
      cyc(0, 8'h00, 1, 0);
    end
  endtask

  task automatic test_flush();
    cyc(1, 8'hE1, 0, 0);
    cyc(1, 8'hE2, 0, 0);
    cyc(1, 8'hE3, 0, 0);
    cyc(1, 8'h99, 1, 1);
    vectors++;
    if (count !== 3'd0 || empty !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_clear: count=%0d empty=%b in_ready=%b out_valid=%b, want 0 1 1 0",
               count, empty, in_ready, out_valid);
    end
    cyc(1, 8'h77, 0, 0);
    vectors++;
    if (count !== 3'd1 || out_valid !== 1'b1 || data_out !== 8'h77) begin
      miscompares++;
      $display("FAIL flush_next_push: count=%0d out_valid=%b data_out=%h, want 1 1 77",
               count, out_valid, data_out);
    end
    cyc(0, 8'h00, 1, 0);
    vectors++;
    if (empty !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_drain: empty=%b, want 1", empty);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      cyc(1, 8'(8'h30 + i), 1, 0);
      vectors++;
      if (count !== 3'd1 || out_valid !== 1'b1 || data_out !== 8'(8'h30 + i)) begin
        miscompares++;
        $display("FAIL stream_%0d: count=%0d out_valid=%b data_out=%h, want 1 1 %h",
                 i, count, out_valid, data_out, 8'(8'h30 + i));
      end
    end
    cyc(0, 8'h00, 1, 0);
    vectors++;
    if (empty !== 1'b1 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL stream_end: empty=%b count=%0d, want 1 0", empty, count);
    end
  endtask

  // DEPTH=3 random run: sequential words, random stalls and rare flushes.
  task automatic test_random_wrap();
    logic [7:0] seq = 8'h01;
    bit iv, ordy, fl, do_push, do_pop;
    for (int n = 0; n < 400; n++) begin
      vectors++;
      if (count3 !== 2'(q3.size()) || out_valid3 !== (q3.size() > 0) ||
          full3 !== (q3.size() == 3) || in_ready3 !== (q3.size() < 3) ||
          (q3.size() > 0 && data_out3 !== q3[0])) begin
        miscompares++;
        $display("FAIL wrap_cycle%0d: count=%0d out_valid=%b full=%b in_ready=%b data_out=%h, want %0d head %h",
                 n, count3, out_valid3, full3, in_ready3, data_out3, q3.size(),
                 (q3.size() > 0) ? q3[0] : 8'h00);
      end
      iv   = (n < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      ordy = (n < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      fl   = (n >= 40) && ($urandom_range(0, 39) == 0);
      in_valid3  = iv;
      data_in3   = seq;
      out_ready3 = ordy;
      flush3     = fl;
      @(posedge clk);
      if (fl) begin
        q3.delete();
      end else begin
        do_pop  = ordy && (q3.size() > 0);
        do_push = iv && (q3.size() < 3);
        if (do_pop) void'(q3.pop_front());
        if (do_push) begin
          q3.push_back(seq);
          seq = seq + 8'h01;
        end
      end
      @(negedge clk);
    end
    in_valid3 = 1'b0;
    out_ready3 = 1'b0;
    flush3 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; data_in = 8'h00;
    in_valid3 = 1'b0; out_ready3 = 1'b0; flush3 = 1'b0; data_in3 = 8'h00;
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_flush();
    test_back_to_back();
    test_random_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hold_queue.md
# hold_queue

Parametrised multi-entry successor to the single-entry hold buffer: a synchronous FIFO that accepts WIDTH-bit words with a valid/ready handshake on input and output and holds up to DEPTH words until the consumer takes them. It sits between any producer and consumer stage in the BPU datapath that need decoupling by more than one word. It also provides occupancy reporting and a synchronous flush. All state is clocked on one clock; there are no edge-triggered control inputs.

## Interface

- WIDTH, 8, data word width in bits (>= 1)
- DEPTH, 4, number of storage entries (>= 2; need not be a power of two)
- CW, $clog2(DEPTH+1), width of count output (derived, not overridden)

- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low
- data_in  input  WIDTH  word offered by producer
- in_valid  input  1  producer has a word on data_in
- in_ready  output  1  queue can accept a word this cycle
- data_out  output  WIDTH  head-of-queue word
- out_valid  output  1  data_out holds a valid word
- out_ready  input  1  consumer takes data_out this cycle
- flush  input  1  synchronous discard of all stored words
- count  output  CW  number of stored words, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0

## Operation

- Push: occurs on a rising edge when in_valid && in_ready; data_in written at write pointer, write pointer advances.
- Pop: occurs on a rising edge when out_valid && out_ready; read pointer advances.
- in_ready = !full; out_valid = !empty. Both derive from registered count only, never combinationally from in_valid/out_ready.
- data_out = storage[read pointer], driven combinationally from storage; value is don't-care while out_valid = 0, except after reset (0).
- Pointers range 0..DEPTH-1 and wrap from DEPTH-1 to 0 (explicit compare, not power-of-two masking).
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Full: in_ready = 0, so no push is possible even if a pop occurs in the same cycle; push accepted the cycle after.
- Empty: out_valid = 0, so no pop. No bypass: a word pushed into an empty queue appears on data_out with out_valid = 1 the next cycle.
- Producer may hold in_valid with in_ready = 0; data_in is sampled only on an accepted push. Consumer may drop out_ready at any time without loss.
- Flush: on a rising edge with flush = 1, pointers and count go to 0. Any push or pop that cycle is ignored. Storage contents are not cleared. Flush has priority over push/pop.
- Reset (rst_n = 0, any time, asynchronous): pointers = 0, count = 0, all storage entries = 0. An operation in flight is abandoned. Outputs after reset: in_ready = 1, out_valid = 0, empty = 1, full = 0, count = 0, data_out = 0.

## Timing

- Latency: push at edge N makes the word visible on data_out and out_valid at edge N+1 if it is the head.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Status outputs (count, full, empty, in_ready, out_valid) change only after rising clk or on rst_n assertion.
- Reset release: first push accepted on the first rising edge with rst_n = 1.
- Flush takes effect at the edge it is sampled; the queue is empty with in_ready = 1 the following cycle.

## Test plan

- Reset/idle: assert rst_n = 0 mid-stream with count = 3 -> immediately count = 0, empty = 1, in_ready = 1, out_valid = 0, data_out = 0.
- Fill/drain (WIDTH=8, DEPTH=4): push 0x11, 0x22, 0x33, 0x44 with out_ready = 0 -> full = 1, in_ready = 0, count = 4. Offer 0x55 -> not accepted. Drain -> data_out sequence 0x11, 0x22, 0x33, 0x44, then empty = 1.
- Wrap-around (DEPTH=3): push/pop 10 words 0x01..0x0A with random stalls -> output order 0x01..0x0A, no loss or duplication, count never exceeds 3.
- Simultaneous push/pop: at count = 2, push 0xAA with pop asserted -> count stays 2, head advances. At count = 4 (full), in_valid = out_ready = 1 -> only the pop occurs, count = 3.
- Flush: with count = 3, assert flush together with in_valid = 1 and out_ready = 1 -> next cycle count = 0, empty = 1, the pushed word is discarded, and the next push 0x77 appears on data_out one cycle later.
- Full-rate streaming: in_valid = out_ready = 1 for 20 cycles from empty -> after a 1-cycle initial latency, one word out per cycle and count settles at 1.
